// File: rtl/mips_rf_pkg.sv
// Shared widths and constants for the MIPS register file slice.
package mips_rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

endpackage : mips_rf_pkg

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, retire clears, set wins on the same address.
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter  int unsigned ADDR_W   = ADDR_W_DEF,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_nxt;

  // Clear applied before set so a new producer overrides a retiring one
  always_comb begin
    busy_nxt = busy_vec;
    if (clr_en && (clr_addr != ADDR_W'(REG_ZERO))) busy_nxt[clr_addr] = 1'b0;
    if (set_en && (set_addr != ADDR_W'(REG_ZERO))) busy_nxt[set_addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

endmodule : rf_scoreboard

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with busy scoreboard and debug read port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_sb
  import mips_rf_pkg::*;
#(
  parameter  int unsigned            DATA_W   = DATA_W_DEF,
  parameter  int unsigned            ADDR_W   = ADDR_W_DEF,
  parameter  logic [DATA_W-1:0]      RST_VAL  = '0,
  localparam int unsigned            NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                ov,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   raddr1,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  output logic                rbusy1,
  output logic                rbusy2,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  // An unknown ov compares unequal to 0, so it blocks the write like ov=1
  always_comb begin
    wr_ok = 1'b0;
    if (we && (ov === 1'b0) && (waddr != ZERO_A)) wr_ok = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == REG_ZERO) ? '0 : RST_VAL;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Retire clears busy even on overflow; the instruction leaves the pipe either way
  rf_scoreboard #(
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (we),
    .clr_addr (waddr),
    .busy_vec (busy_vec)
  );

  always_comb begin
    rdata1   = (raddr1 == ZERO_A) ? '0 : regs[raddr1];
    rdata2   = (raddr2 == ZERO_A) ? '0 : regs[raddr2];
    rbusy1   = busy_vec[raddr1];
    rbusy2   = busy_vec[raddr2];
    dbg_data = (dbg_addr == ZERO_A) ? '0 : regs[dbg_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (raddr1 == waddr)) begin
      rdata1 = wdata;
      rbusy1 = 1'b0;
    end
    if (wr_ok && (raddr2 == waddr)) begin
      rdata2 = wdata;
      rbusy2 = 1'b0;
    end
`endif
  end

endmodule : regfile_sb
